// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response handshake bundle for one alu_arbiter port
//
// Purpose: carries one requester's operation request and its result return.
// Signals:
//   req_valid / req_ready      request handshake (requester -> arbiter)
//   req_opcode, req_op1/op2    operation presented with the request
//   resp_valid / resp_ready    result handshake (arbiter -> requester)
//   resp_result                result bus, qualified by resp_valid
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int WORD_SIZE   = 19,
  parameter int OPCODE_SIZE = 5
);
  logic                   req_valid;
  logic                   req_ready;
  logic [OPCODE_SIZE-1:0] req_opcode;
  logic [WORD_SIZE-1:0]   req_op1;
  logic [WORD_SIZE-1:0]   req_op2;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [WORD_SIZE-1:0]   resp_result;

  modport master (
    output req_valid, req_opcode, req_op1, req_op2, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_opcode, req_op1, req_op2, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter/sequencer for a shared ALU
//
// Purpose: accepts one operation at a time from port0 (execute stage) or
// port1 (address/branch unit), drives the shared ALU for ALU_LATENCY+1
// cycles, captures the result and returns it to the originating port.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   port0, port1               request/response bundles (alu_arbiter_if.slave)
//   alu_control, alu_data_1/2  registered opcode/operands to the ALU
//   alu_result                 ALU result input
//   busy                       high whenever the FSM is not IDLE
module alu_arbiter #(
  parameter int WORD_SIZE   = 19,
  parameter int OPCODE_SIZE = 5,
  parameter int ALU_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_arbiter_if.slave           port0,
  alu_arbiter_if.slave           port1,
  output logic [OPCODE_SIZE-1:0] alu_control,
  output logic [WORD_SIZE-1:0]   alu_data_1,
  output logic [WORD_SIZE-1:0]   alu_data_2,
  input  logic [WORD_SIZE-1:0]   alu_result,
  output logic                   busy
);

  localparam logic [2:0] LAT = 3'(ALU_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 owner;
  logic                 last_grant;
  logic                 grant;
  logic                 accept;
  logic [2:0]           cnt;
  logic [WORD_SIZE-1:0] result;

  // Under contention the port that did not win last time is granted;
  // otherwise the single valid port (port1 only if it alone is valid).
  always_comb begin
    grant = (port0.req_valid && port1.req_valid) ? ~last_grant : port1.req_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    port0.req_ready  = 1'b0;
    port1.req_ready  = 1'b0;
    port0.resp_valid = 1'b0;
    port1.resp_valid = 1'b0;
    busy             = 1'b1;
    accept           = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        // rst_n gate keeps ready low while reset is asserted.
        port0.req_ready = rst_n & port0.req_valid & ~grant;
        port1.req_ready = rst_n & port1.req_valid & grant;
        accept          = port0.req_ready | port1.req_ready;
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (cnt == LAT) begin
          state_next = RESP;
        end
      end
      RESP: begin
        port0.resp_valid = ~owner;
        port1.resp_valid = owner;
        // No accept on the leaving edge: IDLE is only reached next cycle.
        if (owner ? port1.resp_ready : port0.resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU inputs only change on accept, so the ALU sees no churn while
  // waiting in RESP or IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= 3'd0;
      result      <= '0;
      alu_control <= '0;
      alu_data_1  <= '0;
      alu_data_2  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner       <= grant;
            last_grant  <= grant;
            cnt         <= 3'd0;
            alu_control <= grant ? port1.req_opcode : port0.req_opcode;
            alu_data_1  <= grant ? port1.req_op1    : port0.req_op1;
            alu_data_2  <= grant ? port1.req_op2    : port0.req_op2;
          end
        end
        EXEC: begin
          cnt <= cnt + 3'd1;
          if (cnt == LAT) begin
            result <= alu_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign port0.resp_result = result;
  assign port1.resp_result = result;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared 19-bit `arith_logic_unit`. It lets two requesters, the instruction-execute stage (port 0) and the address/branch unit (port 1), share one ALU.
- Each request is accepted with a valid/ready handshake and its opcode and operands are registered.
- The registered values drive the ALU, which has registered output, for a fixed latency.
- The result is captured and returned to the originating port with valid/ready backpressure.
- Only one operation is in flight at a time.

## Interface
Parameters:
- WORD_SIZE, 19, data width (matches `constants::WORD_SIZE`)
- OPCODE_SIZE, 5, ALU opcode width (matches `constants::OPCODE_SIZE`)
- ALU_LATENCY, 1, clock edges from ALU input change to valid `result`; legal range 0..7

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  rising-edge clock
  - rst_n  in  1  asynchronous, active-low reset
- Request ports (N = 0, 1):
  - reqN_valid  in  1  request N is presenting an operation
  - reqN_ready  out  1  arbiter accepts request N this cycle
  - reqN_opcode  in  OPCODE_SIZE  ALU opcode (`opcodes::ADD`, `SUB`, ...)
  - reqN_op1, reqN_op2  in  WORD_SIZE  operands
- Response ports (N = 0, 1):
  - respN_valid  out  1  result for port N available
  - respN_ready  in  1  port N consumes the result
  - resp_result  out  WORD_SIZE  result bus shared by both ports; qualified by respN_valid
- ALU side:
  - alu_control  out  OPCODE_SIZE  to ALU `ALU_control`
  - alu_data_1, alu_data_2  out  WORD_SIZE  to ALU `reg_data_1` / `reg_data_2`
  - alu_result  in  WORD_SIZE  from ALU `result`
- Status:
  - busy  out  1  high in every state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection is combinational from the valid inputs and `last_grant`.
  - If only one port is valid, that port is granted.
  - If both are valid, the port ≠ `last_grant` is granted.
  - reqN_ready is high only for the granted port, and only in IDLE; the non-granted port's ready is 0.
  - On accept (valid & ready at an edge), latch opcode and operands into `alu_control`/`alu_data_*`, record `owner`, set `last_grant := owner`, clear `cnt`, go to EXEC.
- EXEC:
  - ALU outputs are held stable and `cnt` increments every cycle.
  - When `cnt == ALU_LATENCY`, capture `alu_result` into `resp_result` and go to RESP.
- RESP:
  - resp{owner}_valid is high; the other response valid is 0.
  - Stay in RESP until resp{owner}_ready; at that edge go to IDLE.
  - A new request cannot be accepted in that same cycle.
- The ALU outputs keep their last values outside EXEC, so no spurious opcode churn reaches the ALU.
- resp_result holds its value until the next capture.
- Width rules:
  - No width conversion; operands and result pass through at WORD_SIZE.
  - `cnt` is 3 bits.
- Illegal opcodes are forwarded unchanged; the ALU defines their result.

## Timing
- Reset values:
  - state = IDLE, busy = 0
  - req0_ready = req1_ready = 0 until rst_n deasserts; then they follow the combinational IDLE rule
  - resp0_valid = resp1_valid = 0
  - resp_result = 0, alu_control = 0, alu_data_1 = alu_data_2 = 0
  - cnt = 0, owner = 0
  - last_grant = 1, so port 0 wins the first contention
- Latency (accept at edge k):
  - ALU inputs are valid after edge k.
  - The result is captured at edge k+ALU_LATENCY+1, and respN_valid is high from that edge.
  - With ALU_LATENCY = 1, respN_valid rises two edges after accept.
- Throughput: one operation per ALU_LATENCY+3 cycles when respN_ready is held high (IDLE, then EXEC for ALU_LATENCY+1 cycles, then RESP).
- Simultaneous events:
  - Both valid in IDLE: exactly one ready, strictly alternating across consecutive contended grants.
  - A port that drops valid before being accepted loses nothing; there is no request buffering.
- Backpressure: if respN_ready stays low, the FSM stays in RESP indefinitely and both reqN_ready stay 0.
- Asynchronous reset mid-EXEC or mid-RESP: the in-flight operation is discarded, no response is issued, and all outputs take their reset values immediately.

## Test plan
- Single op, port 0, ALU_LATENCY = 1:
  - Stimulus: ADD, 10, 5; resp0_ready = 1.
  - Required: resp0_valid rises 2 edges after accept with resp_result = 15; resp1_valid stays 0.
- Contention, both ports valid at once:
  - Stimulus: port 0 SUB 10,5; port 1 MUL 3,4; both held valid.
  - Required: port 0 is served first (result 5), then port 1 (result 12), then port 0 again.
- Backpressure on port 1:
  - Stimulus: DIV 20,4 with resp1_ready low for 5 cycles.
  - Required: resp1_valid and resp_result = 5 are held stable, busy = 1, both req_ready = 0; returns to IDLE one edge after resp1_ready rises.
- Operand stability:
  - Stimulus: change reqN_op1/op2 during EXEC.
  - Required: alu_data_* unchanged; result of INC on 10 = 11.
- Reset mid-EXEC:
  - Stimulus: pulse rst_n low one cycle after accepting DEC 10.
  - Required: no respN_valid ever asserts; all outputs at reset values; the next request (NOT 19'b1010101010101010101) returns 19'b0101010101010101010.
- Latency sweep:
  - Stimulus: ALU_LATENCY = 0 and 3 with a behavioral ALU model.
  - Required: respN_valid rises at accept + 1 and accept + 4 respectively.
